// File: rtl/iommu_reg_arbiter.sv
// Round-robin arbiter that funnels N_REQ register-bus requesters onto one IOMMU
// register port, with a per-transaction watchdog that completes stuck accesses with an error.
module iommu_reg_arbiter #(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    localparam int IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int STRB_W    = DATA_WIDTH / 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_REQ-1:0]              req_valid_i,
    input  logic [N_REQ-1:0]              req_write_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [N_REQ*STRB_W-1:0]       req_wstrb_i,
    output logic [N_REQ-1:0]              req_ready_o,
    output logic [DATA_WIDTH-1:0]         req_rdata_o,
    output logic                          req_error_o,
    output logic                          reg_valid_o,
    output logic                          reg_write_o,
    output logic [ADDR_WIDTH-1:0]         reg_addr_o,
    output logic [DATA_WIDTH-1:0]         reg_wdata_o,
    output logic [STRB_W-1:0]             reg_wstrb_o,
    input  logic                          reg_ready_i,
    input  logic [DATA_WIDTH-1:0]         reg_rdata_i,
    input  logic                          reg_error_i,
    output logic                          busy_o,
    output logic [IDX_W-1:0]              grant_idx_o,
    output logic                          timeout_o
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_grant;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [WD_W-1:0]   r_wdog;

    logic [ADDR_WIDTH-1:0] w_addr_arr  [N_REQ];
    logic [DATA_WIDTH-1:0] w_wdata_arr [N_REQ];
    logic [STRB_W-1:0]     w_wstrb_arr [N_REQ];

    logic              w_busy;
    logic              w_gnt_valid;
    logic              w_done_ok;
    logic              w_fire;
    logic              w_complete;
    logic              w_found;
    logic              w_hi_found;
    logic [IDX_W-1:0]  w_pick;
    logic [IDX_W-1:0]  w_hi_pick;
    logic [IDX_W-1:0]  w_rr_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign w_addr_arr[gi]  = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata_arr[gi] = req_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_wstrb_arr[gi] = req_wstrb_i[gi*STRB_W +: STRB_W];
            assign req_ready_o[gi] = w_complete && (r_grant == IDX_W'(gi));
        end
    endgenerate

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        w_found    = 1'b0;
        w_pick     = '0;
        w_hi_found = 1'b0;
        w_hi_pick  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(i);
                if (i >= int'(r_rr_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_pick  = IDX_W'(i);
                end
            end
        end
        if (w_hi_found) begin
            w_pick = w_hi_pick;
        end
    end

    assign w_busy      = (r_state == S_BUSY);
    assign w_gnt_valid = req_valid_i[r_grant];
    assign w_rr_next   = (r_grant == IDX_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;

    // A requester withdrawing its valid aborts silently, even if the target answers that cycle.
    assign w_done_ok  = w_busy && w_gnt_valid && reg_ready_i;
    assign w_fire     = (TIMEOUT > 0) && w_busy && w_gnt_valid && !reg_ready_i
                        && (r_wdog == WD_W'(TIMEOUT));
    assign w_complete = w_done_ok || w_fire;

    assign busy_o      = w_busy;
    assign grant_idx_o = r_grant;
    assign timeout_o   = w_fire;
    assign req_rdata_o = w_done_ok ? reg_rdata_i : '0;
    assign req_error_o = w_done_ok ? reg_error_i : w_fire;

    assign reg_valid_o = w_busy;
    assign reg_write_o = w_busy ? req_write_i[r_grant] : 1'b0;
    assign reg_addr_o  = w_busy ? w_addr_arr[r_grant]  : '0;
    assign reg_wdata_o = w_busy ? w_wdata_arr[r_grant] : '0;
    assign reg_wstrb_o = w_busy ? w_wstrb_arr[r_grant] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_wdog   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_wdog  <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!w_gnt_valid) begin
                        r_state <= S_IDLE;
                    end else if (w_complete) begin
                        r_rr_ptr <= w_rr_next;
                        r_state  <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/iommu_reg_arbiter.md
IOMMU_REG_ARBITER -- requirements
Module: iommu_reg_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, number of register-bus requesters (legal range 2..8).
REQ-002 Parameter ADDR_WIDTH, default 32, register-bus address width.
REQ-003 Parameter DATA_WIDTH, default 32, register-bus data width (multiple of 8).
REQ-004 Parameter TIMEOUT, default 255, maximum BUSY cycles without downstream ready (0 disables the watchdog).
REQ-005 Port clk_i  input  1  rising-edge clock; the block uses one clock only.
REQ-006 Port rst_ni  input  1  reset, asynchronous and active-low.
REQ-007 Port req_valid_i  input  N_REQ  per-requester request valid.
REQ-008 Port req_write_i  input  N_REQ  per-requester write (1) / read (0).
REQ-009 Port req_addr_i  input  N_REQ*ADDR_WIDTH  per-requester address; slice i belongs to requester i.
REQ-010 Port req_wdata_i  input  N_REQ*DATA_WIDTH  per-requester write data.
REQ-011 Port req_wstrb_i  input  N_REQ*DATA_WIDTH/8  per-requester byte strobes.
REQ-012 Port req_ready_o  output  N_REQ  one-hot completion pulse to the granted requester.
REQ-013 Port req_rdata_o  output  DATA_WIDTH  shared read data, valid only with a req_ready_o bit.
REQ-014 Port req_error_o  output  1  shared error flag, valid only with a req_ready_o bit.
REQ-015 Port reg_valid_o, reg_write_o, reg_addr_o, reg_wdata_o, reg_wstrb_o  outputs  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  downstream request toward the IOMMU register map.
REQ-016 Port reg_ready_i, reg_rdata_i, reg_error_i  inputs  1/DATA_WIDTH/1  downstream response.
REQ-017 Port busy_o  output  1  high while in BUSY.
REQ-018 Port grant_idx_o  output  max(1,$clog2(N_REQ))  index of the current or last granted requester.
REQ-019 Port timeout_o  output  1  single-cycle pulse when the watchdog fires.

Function
REQ-020 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-021 In IDLE, with any req_valid_i bit set, the block SHALL register a grant to the first set bit found searching upward (with wrap) from round-robin pointer rr_ptr, and SHALL enter BUSY on the next edge.
REQ-022 Grant latency SHALL be exactly one cycle: reg_valid_o is 0 in IDLE and is asserted from the first BUSY cycle.
REQ-023 In BUSY, reg_valid_o SHALL be 1 and reg_write/addr/wdata/wstrb SHALL combinationally mirror the granted requester's slice; requesters SHALL hold their signals stable until ready.
REQ-024 In a BUSY cycle with reg_ready_i=1, the block SHALL assert req_ready_o[grant] for that cycle only, drive req_rdata_o=reg_rdata_i and req_error_o=reg_error_i, set rr_ptr=(grant+1) mod N_REQ, and return to IDLE.
REQ-025 Outside a completion cycle, req_ready_o SHALL be 0, req_rdata_o all zeros and req_error_o 0.
REQ-026 A watchdog counter SHALL clear on BUSY entry and increment each BUSY cycle with reg_ready_i=0.
REQ-027 If TIMEOUT>0 and the counter equals TIMEOUT with reg_ready_i=0, the block SHALL complete the grant with req_error_o=1 and req_rdata_o=0, pulse timeout_o, deassert reg_valid_o, advance rr_ptr and return to IDLE.
REQ-028 If reg_ready_i=1 in the same cycle the watchdog would fire, the normal completion SHALL win and timeout_o SHALL stay 0.
REQ-029 If the granted requester drops req_valid_i while in BUSY, the block SHALL return to IDLE with no req_ready_o pulse and no rr_ptr update.
REQ-030 A requester completed in cycle t SHALL NOT be granted again until the cycle after it returns to IDLE; back-to-back transactions SHALL therefore each take at least 2 cycles.
REQ-031 Requests arriving while BUSY SHALL wait; they SHALL never be dropped or reordered by the block.

Reset
REQ-032 On rst_ni=0, asynchronously and regardless of state: state=IDLE, rr_ptr=0, grant=0, watchdog=0.
REQ-033 During reset, all outputs SHALL be 0: reg_valid_o, req_ready_o, req_error_o, busy_o, timeout_o, grant_idx_o, and all data buses.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction with no completion pulse.

Verification
REQ-035 Single read: req 0, addr 0x10, reg_ready_i one cycle after reg_valid_o, rdata 0xCAFE0001 -> req_ready_o=01 and req_rdata_o=0xCAFE0001 in that cycle; busy_o high for 2 cycles.
REQ-036 Fairness: both requesters hold valid for 6 transactions with immediate ready -> grants 0,1,0,1,0,1.
REQ-037 Timeout: TIMEOUT=4, reg_ready_i held 0 -> completion on the 5th BUSY cycle with req_error_o=1, rdata=0 and a timeout_o pulse; the next grant goes to the other requester.
REQ-038 Race: reg_ready_i=1 exactly on the watchdog cycle -> normal completion, timeout_o=0, req_error_o=reg_error_i.
REQ-039 Abort paths: requester drops valid in BUSY -> IDLE with no pulse and rr_ptr unchanged; rst_ni low in BUSY -> all outputs 0 immediately, first grant after reset goes to requester 0.
